// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: shared fetch widths, PC step, default queue depth and queue entry type
`ifndef PC_LENGTH
`define PC_LENGTH 32
`endif
`ifndef INST_LENGTH
`define INST_LENGTH 32
`endif
`ifndef PC_STEP
`define PC_STEP 4
`endif
`ifndef IFQ_DEPTH
`define IFQ_DEPTH 4
`endif
package if_prefetch_pkg;
  localparam int PC_W = `PC_LENGTH;
  localparam int INST_W = `INST_LENGTH;
  localparam logic [PC_W-1:0] PC_INC = PC_W'(`PC_STEP);
  localparam int IFQ_DEPTH = `IFQ_DEPTH;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0] pc;
  } ifqEntry_t;
endpackage

// File: rtl/if_prefetch_fifo.sv
// ifq_fifo: synchronous FIFO with push, pop, clear, occupancy count and combinational zeroed-when-empty head
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic doPush, doPop;
  assign doPop = pop && count != '0;
  assign doPush = push && (count != FULL || doPop);
  assign head = count != '0 ? mem[rdPtr] : '0;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= din;
  a_noOverflow: assert property (@(posedge clk) disable iff (rst || clear) !(push && count == FULL && !doPop));
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: credit-based instruction prefetch into a queue for decode; IFQ_REDIRECT_EN adds flush/redirect ports
module if_prefetch import if_prefetch_pkg::*; #(
  parameter int DEPTH = IFQ_DEPTH,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc,
  output logic              romCe,
  input  logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] instOut,
  output logic [PC_W-1:0]   instPc,
  output logic              instValid,
  input  logic              instReady
`ifdef IFQ_REDIRECT_EN
  ,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirectPc
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  logic flush;
  logic [PC_W-1:0] flushPc;
`ifdef IFQ_REDIRECT_EN
  assign flush = redirect;
  assign flushPc = redirectPc & ~PC_W'(3);
`else
  assign flush = 1'b0;
  assign flushPc = RST_PC;
`endif
  logic pend, pop, credit;
  logic [PC_W-1:0] issuedPc;
  logic [CW-1:0] count;
  ifqEntry_t head, pushEntry;
  assign instValid = count != '0 && !flush;
  assign pop = instValid && instReady;
  assign instOut = head.inst;
  assign instPc = head.pc;
  assign pushEntry = '{inst: inst, pc: issuedPc};
  // queued + in flight + issuing now + the next fetch must fit after this pop
  assign credit = int'(count) + int'(pend) + int'(romCe) < DEPTH + int'(pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RST_PC;
      romCe <= 1'b0;
      pend <= 1'b0;
      issuedPc <= '0;
    end else begin
      pc <= flush ? flushPc : romCe ? pc + PC_INC : pc;
      romCe <= flush || credit;
      pend <= romCe && !flush;
      if (romCe) issuedPc <= pc;
    end
  end
  ifq_fifo #(.DEPTH(DEPTH), .W($bits(ifqEntry_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(pend && !flush),
    .pop(pop),
    .clear(flush),
    .din(pushEntry),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed table, hand sequences and random traffic against a fetch-queue scoreboard model
module tb_if_prefetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
`ifdef IFQ_REDIRECT_EN
  localparam bit HAS_REDIR = 1'b1;
`else
  localparam bit HAS_REDIR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, instReady = 1'b0;
  logic [31:0] pc, inst, instOut, instPc, pc2, inst2, instOut2, instPc2;
  logic romCe, instValid, romCe2, instValid2;
`ifdef IFQ_REDIRECT_EN
  logic redirect = 1'b0;
  logic [31:0] redirectPc = '0;
`endif
  int total = 0, bad = 0, now = 0;
  bit known = 1'b0;
  bit expCe;
  logic [31:0] expPc;
  typedef struct { logic [31:0] pc; int avail; } fetch_t;
  fetch_t q[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] romData(input logic [31:0] a);
    return a ^ (a << 16);
  endfunction
  always @(posedge clk) begin
    inst <= romCe ? romData(pc) : 32'hDEAD_BEEF;
    inst2 <= romCe2 ? romData(pc2) : 32'hDEAD_BEEF;
  end
  if_prefetch #(.DEPTH(DEPTH), .RST_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .romCe(romCe), .inst(inst),
    .instOut(instOut), .instPc(instPc), .instValid(instValid), .instReady(instReady)
`ifdef IFQ_REDIRECT_EN
    , .redirect(redirect), .redirectPc(redirectPc)
`endif
  );
  if_prefetch #(.DEPTH(DEPTH), .RST_PC(WRAP_PC)) dutWrap (
    .clk(clk), .rst(rst), .pc(pc2), .romCe(romCe2), .inst(inst2),
    .instOut(instOut2), .instPc(instPc2), .instValid(instValid2), .instReady(1'b1)
`ifdef IFQ_REDIRECT_EN
    , .redirect(1'b0), .redirectPc(32'h0)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, now, act, exp);
    end
  endtask
  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %b want %b", name, now, act, exp);
    end
  endtask
  // one clock: drive inputs, check against the scoreboard, then advance the model
  task automatic cyc(input logic r, input logic rd, input logic rdir, input logic [31:0] rpc);
    bit avail, expValid, pop, rdirEff;
    logic [31:0] hPc;
    @(negedge clk);
    rst = r;
    instReady = rd;
`ifdef IFQ_REDIRECT_EN
    redirect = rdir;
    redirectPc = rpc;
`endif
    #1;
    rdirEff = HAS_REDIR && rdir;
    if (known) begin
      avail = q.size() > 0 && q[0].avail <= now;
      expValid = avail && !rdirEff;
      hPc = avail ? q[0].pc : 32'h0;
      chkb("romCe", romCe, expCe);
      chk("pc", pc, expPc);
      chkb("instValid", instValid, expValid);
      chk("instPc", instPc, hPc);
      chk("instOut", instOut, avail ? romData(hPc) : 32'h0);
      pop = expValid && rd;
      if (r) begin
        q.delete();
        expCe = 1'b0;
        expPc = RST_PC;
      end else if (rdirEff) begin
        q.delete();
        expCe = 1'b1;
        expPc = rpc & ~32'd3;
      end else begin
        if (pop) void'(q.pop_front());
        if (expCe) q.push_back('{expPc, now + 2});
        expPc = expCe ? expPc + 32'd4 : expPc;
        expCe = q.size() + 1 <= DEPTH;
      end
    end else if (r) begin
      known = 1'b1;
      q.delete();
      expCe = 1'b0;
      expPc = RST_PC;
    end
    now++;
  endtask
  typedef struct {
    logic ready;
    logic ce;
    logic [31:0] pc;
    logic valid;
    logic [31:0] ipc;
    logic [31:0] wpc;
  } vec_t;
  vec_t vecs[7];
  initial begin
    int k, ces;
    bit seen;
    logic [31:0] first;
    vecs[0] = '{1'b1, 1'b0, 32'd0,  1'b0, 32'd0,  32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  32'hFFFF_FFF8};
    vecs[4] = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  32'hFFFF_FFFC};
    vecs[5] = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  32'h0};
    vecs[6] = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12, 32'h4};
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, vecs[i].ready, 0, 0);
      chkb("tblCe", romCe, vecs[i].ce);
      chk("tblPc", pc, vecs[i].pc);
      chkb("tblValid", instValid, vecs[i].valid);
      chk("tblInstPc", instPc, vecs[i].ipc);
      chk("tblInstOut", instOut, romData(vecs[i].ipc));
      chkb("wrapValid", instValid2, vecs[i].valid);
      chk("wrapInstPc", instPc2, vecs[i].wpc);
    end
    cyc(1, 0, 0, 0);
    ces = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      if (romCe) ces++;
    end
    chk("bpFetches", 32'(ces), 32'd4);
    chk("bpHeadPc", instPc, 32'd0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0);
      if (instValid) begin
        chk("bpOrder", instPc, 32'(k * 4));
        k++;
      end
    end
    chk("bpPops", 32'(k), 32'd10);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chkb("rstValid", instValid, 1'b0);
    chk("rstPc", pc, RST_PC);
    chkb("rstCe", romCe, 1'b0);
    cyc(0, 0, 0, 0);
    chkb("rstRestart", romCe, 1'b1);
`ifdef IFQ_REDIRECT_EN
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h100);
    chkb("redirValid", instValid, 1'b0);
    cyc(0, 1, 0, 0);
    chk("redirPc", pc, 32'h100);
    chkb("redirCe", romCe, 1'b1);
    seen = 1'b0;
    first = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0);
      if (instValid && !seen) begin
        seen = 1'b1;
        first = instPc;
      end
    end
    chkb("redirSeen", seen, 1'b1);
    chk("redirFirst", first, 32'h100);
    cyc(0, 1, 1, 32'h103);
    cyc(0, 1, 0, 0);
    chk("redirAlign", pc, 32'h100);
`endif
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
